exu_lsu_queue: RTL and testbench

- Parametrised load/store unit for the execution stage; generalises the single-shot exu load/store outputs.
- Buffers up to DEPTH memory requests in order and performs address generation and alignment checking.
- Issues requests on a valid/ready memory port and extracts and sign-extends load data onto the register write port.
- Sits between the exu ALU/decode path and the data-memory interface; asserts stall to ifu/dec when full.

---
 rtl/exu_lsu_queue.sv | 229 ++++++++++++++++++++++
 tb/tb_exu_lsu_queue.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_lsu_queue.sv
// exu_lsu_queue: in-order load/store queue for the execution stage.
// Buffers up to DEPTH aligned requests, issues them one at a time on a
// valid/ready memory port, and writes extracted/extended load data back to
// the register file. Misaligned requests are dropped with a one-cycle pulse.
//
// Ports:
//   hclk, hrst        clock, synchronous active-high reset
//   req_*             request from exu (valid/ready, address parts, data)
//   mem_*             data-memory request port and read response
//   reg_w*            register write port for load results
//   lsu_misalign      pulse on a rejected (misaligned) request
//   lsu_busy          queue non-empty or a transaction in flight
//   ifu_dec_stall     queue full
// Optional: define LSU_PERF_EN to add perf_loads, perf_stores and
// perf_stall_cycles saturating counters.
module exu_lsu_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic              hclk,
  input  logic              hrst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [1:0]        req_size,
  input  logic              req_sext,
  input  logic [4:0]        req_rd,
  input  logic [XLEN-1:0]   req_base_addr,
  input  logic [XLEN-1:0]   req_offset,
  input  logic [XLEN-1:0]   req_store_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_write,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              reg_wen,
  output logic [4:0]        reg_waddr,
  output logic [XLEN-1:0]   reg_wdata,
  output logic              lsu_misalign,
  output logic              lsu_busy,
  output logic              ifu_dec_stall
`ifdef LSU_PERF_EN
  ,
  output logic [31:0]       perf_loads,
  output logic [31:0]       perf_stores,
  output logic [31:0]       perf_stall_cycles
`endif
);

  localparam int unsigned STRB_W = XLEN / 8;
  localparam int unsigned LANE_W = $clog2(STRB_W);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic [1:0]      size;
    logic            sext;
    logic            is_store;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R} state_t;

  state_t             state_q, state_d;
  entry_t             fifo_q [DEPTH];
  logic [PTR_W-1:0]   head_q, tail_q, head_d, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [XLEN-1:0]    req_addr;
  logic               misalign, accept, push, pop;
  entry_t             new_e, head_e, next_e;
  logic [XLEN-1:0]    st_wdata;
  logic [STRB_W-1:0]  st_wstrb;
  logic [XLEN-1:0]    ld_result;

  // Byte-enable pattern for an access size, before lane shifting.
  function automatic logic [STRB_W-1:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return STRB_W'(1);
      2'd1:    return STRB_W'(3);
      2'd2:    return STRB_W'(15);
      default: return {STRB_W{1'b1}};
    endcase
  endfunction

  // Shift the addressed lane down, keep the access width, then extend.
  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] raw,
                                                   input logic [LANE_W-1:0] lane,
                                                   input logic [1:0] size,
                                                   input logic sext);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] keep;
    logic            sign;
    sh = raw >> {lane, 3'b000};
    case (size)
      2'd0:    begin keep = XLEN'(8'hFF);         sign = sh[7];      end
      2'd1:    begin keep = XLEN'(16'hFFFF);      sign = sh[15];     end
      2'd2:    begin keep = XLEN'(32'hFFFF_FFFF); sign = sh[31];     end
      default: begin keep = '1;                   sign = sh[XLEN-1]; end
    endcase
    return (sh & keep) | ((sext && sign) ? ~keep : '0);
  endfunction

  // Address generation and alignment check on the incoming request.
  always_comb begin
    req_addr = req_base_addr + req_offset;
    case (req_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = req_addr[0];
      2'd2:    misalign = |req_addr[1:0];
      default: misalign = (XLEN == 32) || (|req_addr[2:0]);
    endcase
    accept = req_valid && req_ready;
    push   = accept && !misalign;

    new_e          = '0;
    new_e.addr     = req_addr;
    new_e.data     = req_store_data;
    new_e.rd       = req_rd;
    new_e.size     = req_size;
    new_e.sext     = req_sext;
    new_e.is_store = req_is_store;
  end

  // Queue bookkeeping; head entry leaves on store handshake or load response.
  always_comb begin
    head_e  = fifo_q[head_q];
    pop     = ((state_q == ISSUE) && head_e.is_store && mem_ready) ||
              ((state_q == WAIT_R) && mem_rvalid);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    // A push into a queue that is empty after this cycle's pop becomes the head.
    next_e  = (push && ((count_q - CNT_W'(pop)) == '0)) ? new_e : fifo_q[head_d];
    st_wdata = next_e.data << {next_e.addr[LANE_W-1:0], 3'b000};
    st_wstrb = size_mask(next_e.size) << next_e.addr[LANE_W-1:0];
    ld_result = load_extract(mem_rdata, head_e.addr[LANE_W-1:0], head_e.size, head_e.sext);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if ((count_q != '0) || push) state_d = ISSUE;
      ISSUE:   if (mem_ready) begin
                 if (head_e.is_store) state_d = (count_d != '0) ? ISSUE : IDLE;
                 else                 state_d = WAIT_R;
               end
      WAIT_R:  if (mem_rvalid) state_d = (count_d != '0) ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Entry storage; flushed logically by the pointer reset.
  always_ff @(posedge hclk) begin
    if (!hrst && push) fifo_q[tail_q] <= new_e;
  end

  // State, pointers and registered outputs.
  always_ff @(posedge hclk) begin
    if (hrst) begin
      state_q       <= IDLE;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      req_ready     <= 1'b0;
      ifu_dec_stall <= 1'b0;
      lsu_busy      <= 1'b0;
      lsu_misalign  <= 1'b0;
      mem_valid     <= 1'b0;
      mem_write     <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wstrb     <= '0;
      reg_wen       <= 1'b0;
      reg_waddr     <= '0;
      reg_wdata     <= '0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      req_ready     <= (count_d != CNT_W'(DEPTH));
      ifu_dec_stall <= (count_d == CNT_W'(DEPTH));
      lsu_busy      <= (count_d != '0) || (state_d != IDLE);
      lsu_misalign  <= accept && misalign;
      mem_valid     <= (state_d == ISSUE);
      if (state_d == ISSUE) begin
        mem_write <= next_e.is_store;
        mem_addr  <= next_e.addr;
        mem_wdata <= next_e.is_store ? st_wdata : '0;
        mem_wstrb <= next_e.is_store ? st_wstrb : '0;
      end else begin
        mem_write <= 1'b0;
        mem_addr  <= '0;
        mem_wdata <= '0;
        mem_wstrb <= '0;
      end
      reg_wen <= (state_q == WAIT_R) && mem_rvalid && (head_e.rd != 5'd0);
      if ((state_q == WAIT_R) && mem_rvalid) begin
        reg_waddr <= head_e.rd;
        reg_wdata <= ld_result;
      end
    end
  end

`ifdef LSU_PERF_EN
  // Saturating event counters.
  always_ff @(posedge hclk) begin
    if (hrst) begin
      perf_loads        <= '0;
      perf_stores       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if ((state_q == WAIT_R) && mem_rvalid && (perf_loads != '1))
        perf_loads <= perf_loads + 32'd1;
      if ((state_q == ISSUE) && head_e.is_store && mem_ready && (perf_stores != '1))
        perf_stores <= perf_stores + 32'd1;
      if (ifu_dec_stall && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exu_lsu_queue.sv
// Testbench for exu_lsu_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_exu_lsu_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic              hclk = 1'b0;
  logic              hrst;
  logic              req_valid, req_ready, req_is_store, req_sext;
  logic [1:0]        req_size;
  logic [4:0]        req_rd;
  logic [XLEN-1:0]   req_base_addr, req_offset, req_store_data;
  logic              mem_valid, mem_ready, mem_write, mem_rvalid;
  logic [XLEN-1:0]   mem_addr, mem_wdata, mem_rdata;
  logic [XLEN/8-1:0] mem_wstrb;
  logic              reg_wen;
  logic [4:0]        reg_waddr;
  logic [XLEN-1:0]   reg_wdata;
  logic              lsu_misalign, lsu_busy, ifu_dec_stall;
`ifdef LSU_PERF_EN
  logic [31:0]       perf_loads, perf_stores, perf_stall_cycles;
`endif

  always #5 hclk = ~hclk;

  exu_lsu_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .hclk(hclk), .hrst(hrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_size(req_size), .req_sext(req_sext), .req_rd(req_rd),
    .req_base_addr(req_base_addr), .req_offset(req_offset), .req_store_data(req_store_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .lsu_misalign(lsu_misalign), .lsu_busy(lsu_busy), .ifu_dec_stall(ifu_dec_stall)
`ifdef LSU_PERF_EN
    , .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [1:0]  size;
    logic        sext;
    logic        st;
  } req_t;

  int          errors = 0;
  int          checks = 0;
  req_t        expq[$];
  logic        outst = 1'b0;
  req_t        out_e;
  int          dly = 0;
  logic        force_en = 1'b0;
  logic [31:0] force_rd = '0;
  int          n_load_hs = 0;
  int          seen_wen = 0;
  logic [31:0] last_wdata = '0;
  logic [4:0]  last_waddr = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic is_mis(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    return (a % (32'd1 << sz)) != 32'd0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] raw, input logic [31:0] a,
                                           input logic [1:0] sz, input logic sx);
    logic [63:0] v, m;
    int nb;
    nb = 1 << sz;
    v  = {32'd0, raw} >> (8 * a[1:0]);
    m  = (64'd1 << (8 * nb)) - 64'd1;
    v  = v & m;
    if (sx && v[8*nb-1]) v = v | ~m;
    return v[31:0];
  endfunction

  function automatic logic [3:0] exp_strb(input logic [31:0] a, input logic [1:0] sz);
    logic [7:0] m;
    m = ((8'd1 << (1 << sz)) - 8'd1) << a[1:0];
    return m[3:0];
  endfunction

  // One clock of stimulus: drive the responder, update the model, then check outputs.
  task automatic tick();
    logic [31:0] a;
    logic [31:0] w;
    req_t        e;
    logic        exp_mis, exp_wen;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
    int          occ;
    exp_mis = 1'b0; exp_wen = 1'b0; exp_wa = '0; exp_wd = '0;
    mem_rvalid = 1'b0;
    if (outst) begin
      if (dly == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = force_en ? force_rd : $urandom;
      end else dly--;
    end
    if (mem_rvalid) begin
      outst   = 1'b0;
      exp_wen = (out_e.rd != 5'd0);
      exp_wa  = out_e.rd;
      exp_wd  = exp_load(mem_rdata, out_e.addr, out_e.size, out_e.sext);
    end
    if (req_valid && req_ready) begin
      a = req_base_addr + req_offset;
      if (is_mis(a, req_size)) exp_mis = 1'b1;
      else begin
        e.addr = a; e.data = req_store_data; e.rd = req_rd;
        e.size = req_size; e.sext = req_sext; e.st = req_is_store;
        expq.push_back(e);
      end
    end
    if (mem_valid && mem_ready) begin
      if (expq.size() == 0) check_val("mem_spurious", 1, 0);
      else begin
        e = expq.pop_front();
        check_val("mem_write", mem_write, e.st);
        check_val("mem_addr", mem_addr, e.addr);
        if (e.st) begin
          w = e.data << (8 * e.addr[1:0]);
          check_val("mem_wdata", mem_wdata, w);
          check_val("mem_wstrb", mem_wstrb, exp_strb(e.addr, e.size));
        end else begin
          outst = 1'b1;
          out_e = e;
          dly   = $urandom_range(0, 2);
          n_load_hs++;
        end
      end
    end
    @(posedge hclk); #1;
    mem_rvalid = 1'b0;
    if (reg_wen) seen_wen++;
    check_val("misalign", lsu_misalign, exp_mis);
    check_val("reg_wen", reg_wen, exp_wen);
    if (exp_wen) begin
      check_val("reg_waddr", reg_waddr, exp_wa);
      check_val("reg_wdata", reg_wdata, exp_wd);
      last_wdata = reg_wdata;
      last_waddr = reg_waddr;
    end
    occ = expq.size() + (outst ? 1 : 0);
    check_val("req_ready", req_ready, occ < DEPTH);
    check_val("stall", ifu_dec_stall, occ == DEPTH);
    check_val("busy", lsu_busy, occ != 0);
    check_val("mem_valid", mem_valid, (expq.size() != 0) && !outst);
  endtask

  task automatic run_req(input logic st, input logic [1:0] sz, input logic sx, input logic [4:0] rd,
                         input logic [31:0] base, input logic [31:0] off, input logic [31:0] data);
    req_is_store = st; req_size = sz; req_sext = sx; req_rd = rd;
    req_base_addr = base; req_offset = off; req_store_data = data;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    mem_ready = 1'b1;
    while ((outst || expq.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check_val("drain_done", n < budget, 1);
  endtask

  task automatic do_reset();
    hrst = 1'b1; req_valid = 1'b0; mem_rvalid = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    check_val("rst_ctrl", {mem_valid, mem_write, mem_wstrb, reg_wen, reg_waddr,
                           lsu_misalign, lsu_busy, ifu_dec_stall, req_ready}, 0);
    check_val("rst_maddr", mem_addr, 0);
    check_val("rst_mwdata", mem_wdata, 0);
    check_val("rst_rwdata", reg_wdata, 0);
    hrst = 1'b0;
    expq.delete();
    outst = 1'b0;
    @(posedge hclk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    hrst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_size = '0; req_sext = 1'b0;
    req_rd = '0; req_base_addr = '0; req_offset = '0; req_store_data = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    do_reset();

    // sw 0x1004
    mem_ready = 1'b1;
    run_req(1'b1, 2'd2, 1'b0, 5'd0, 32'h1000, 32'd4, 32'hDEAD_BEEF);
    check_val("sw_valid", mem_valid, 1);
    check_val("sw_addr", mem_addr, 32'h1004);
    check_val("sw_wstrb", mem_wstrb, 4'hF);
    check_val("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    check_val("sw_idle", lsu_busy, 0);

    // lb / lbu at 0x2003
    force_en = 1'b1; force_rd = 32'h80AA_BBCC;
    seen_wen = 0;
    run_req(1'b0, 2'd0, 1'b1, 5'd5, 32'h2000, 32'd3, 32'd0);
    drain(20);
    check_val("lb_wen_cnt", seen_wen, 1);
    check_val("lb_waddr", last_waddr, 5);
    check_val("lb_data", last_wdata, 32'hFFFF_FF80);
    run_req(1'b0, 2'd0, 1'b0, 5'd5, 32'h2000, 32'd3, 32'd0);
    drain(20);
    check_val("lbu_data", last_wdata, 32'h0000_0080);
    force_en = 1'b0;

    // lh at 0x3001 is rejected
    run_req(1'b0, 2'd1, 1'b1, 5'd7, 32'h3000, 32'd1, 32'd0);
    check_val("mis_pulse", lsu_misalign, 1);
    check_val("mis_novalid", mem_valid, 0);
    tick();
    check_val("mis_end", lsu_misalign, 0);
    check_val("mis_empty", lsu_busy, 0);

    // Fill the queue with the port stalled, then drain in order
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      run_req(1'b1, 2'd2, 1'b0, 5'd0, 32'h100, 32'(4 * i), 32'(i));
    check_val("full_ready", req_ready, 0);
    check_val("full_stall", ifu_dec_stall, 1);
    run_req(1'b1, 2'd2, 1'b0, 5'd0, 32'h200, 32'd0, 32'd9);
    mem_ready = 1'b1;
    tick();
    check_val("stall_release", ifu_dec_stall, 0);
    drain(20);

    // lw x0 performs the bus read without a writeback
    do_reset();
    n0 = n_load_hs; seen_wen = 0;
    mem_ready = 1'b1;
    run_req(1'b0, 2'd2, 1'b0, 5'd0, 32'h40, 32'd0, 32'd0);
    drain(20);
    check_val("x0_bus_read", n_load_hs - n0, 1);
    check_val("x0_no_wen", seen_wen, 0);
`ifdef LSU_PERF_EN
    check_val("perf_loads", perf_loads, 1);
`endif

    // Reset while waiting for read data; late response must be ignored
    run_req(1'b0, 2'd2, 1'b0, 5'd9, 32'h80, 32'd0, 32'd0);
    tick();
    check_val("wr_wait", {mem_valid, lsu_busy}, 2'b01);
    hrst = 1'b1;
    @(posedge hclk); #1;
    check_val("mr_rst_ctrl", {mem_valid, reg_wen, lsu_busy, req_ready, ifu_dec_stall}, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge hclk); #1;
    hrst = 1'b0;
    @(posedge hclk); #1;
    mem_rvalid = 1'b0;
    check_val("mr_no_wen", reg_wen, 0);
    check_val("mr_idle", {mem_valid, lsu_busy}, 0);
    @(posedge hclk); #1;
    check_val("mr_no_wen2", reg_wen, 0);
    check_val("mr_ready", req_ready, 1);
    expq.delete(); outst = 1'b0;
`ifdef LSU_PERF_EN
    check_val("perf_loads_rst", perf_loads, 0);
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 7);
      req_valid      = $urandom_range(0, 1) == 1;
      req_is_store   = $urandom_range(0, 1) == 1;
      req_size       = (r == 7) ? 2'd3 : 2'(r % 3);
      req_sext       = $urandom_range(0, 1) == 1;
      req_rd         = 5'($urandom);
      req_base_addr  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'h7);
      req_offset     = 32'($urandom_range(0, 7)) * 32'd8 - 32'd32;
      req_store_data = $urandom;
      mem_ready      = $urandom_range(0, 9) < 7;
      tick();
    end
    req_valid = 1'b0;
    drain(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
